arrow_spawner: RTL and testbench
================================

// Module: arrow_spawner
// PURPOSE
//  Upstream scheduler for the arrow instances. It owns NUM_SLOTS arrow lanes and drives each lane's
//  valid/direction/speed/inversed inputs. It launches a new arrow every SPAWN_PERIOD frames with
//  an LFSR-chosen direction, and retires lanes on player hit or lifetime expiry.
//  It also counts hits for the HP/score logic and raises arrow speed as spawns accumulate.
// PARAMETERS
//  NUM_SLOTS     4    number of arrow lanes driven (1..8)
//  SPAWN_PERIOD  60   frames between spawn attempts (>=2)
//  LIFE_FRAMES   200  frames after which an un-hit ACTIVE lane is force-retired
//  LEVEL_SPAWNS  8    successful spawns per speed-level increment
// PORTS
//  clk             in   1            pixel clock
//  rst             in   1            asynchronous, active-low reset
//  game_active_in  in   1            1 = game running; fall starts drain
//  hcount_in       in   11           raster x; frame tick = (hcount_in==0 && vcount_in==0)
//  vcount_in       in   10           raster y
//  hit_in          in   NUM_SLOTS    per-lane hit_player from arrow instances (may be sticky)
//  valid_out       out  NUM_SLOTS    per-lane valid_in to arrow instances
//  direction_out   out  2*NUM_SLOTS  lane i at [2i+1:2i]; dir_t encoding
//  speed_out       out  3*NUM_SLOTS  lane i at [3i+2:3i]
//  inversed_out    out  NUM_SLOTS    per-lane inversed flag
//  hit_pulse_out   out  1            1-cycle pulse when >=1 lane retires by hit
//  hit_count_out   out  8            saturating total hits (255 max)
//  busy_out        out  1            1 when any lane is not FREE
// BEHAVIOUR
//  Reset: all outputs 0; lanes FREE; FSM IDLE; counters 0; level 0; LFSR = LFSR_SEED. Asserting
//   reset mid-game drops every valid_out in the same cycle. This is asynchronous.
//  Global FSM: IDLE -(game_active_in=1)-> RUN -(game_active_in=0)-> DRAIN -(all lanes FREE)-> IDLE.
//   DRAIN -(game_active_in=1)-> RUN. Spawns occur only in RUN. On IDLE->RUN, spawn_cnt and level clear.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock; it never holds 0.
//  Spawn: on each frame tick in RUN, spawn_cnt increments. When spawn_cnt==SPAWN_PERIOD-1, it
//   wraps to 0 and the lowest-index FREE lane becomes ACTIVE. If no lane is FREE, the attempt is dropped.
//   Lane assignment, registered on that edge: valid=1, direction=LFSR[1:0], speed=1+level.
//   All lane fields change on the same edge; they are held stable while the lane is ACTIVE.
//  Level: increments after every LEVEL_SPAWNS successful spawns and saturates at 6 (speed<=7).
//  Lane FSM: FREE -> ACTIVE -> RETIRE -> FREE.
//   ACTIVE->RETIRE on a rising edge of hit_in[i] (hit_in & ~hit_q). The hit_q registers are
//    registered every clock.
//   ACTIVE->RETIRE also when life_cnt[i] reaches LIFE_FRAMES-1 on a frame tick.
//   If both occur in the same cycle, it counts as a hit.
//   RETIRE lasts exactly 1 cycle with valid=0, so the arrow sees a fresh rising edge on reuse.
//   life_cnt clears on spawn.
//   A lane in RETIRE is not FREE, so it cannot be re-spawned in the same cycle.
//  Hits: hit_count_out += popcount(lanes retiring by hit this cycle), saturating at 255.
//   hit_pulse_out is high for 1 cycle, registered, 1 clock after the retire edge.
//   Multiple simultaneous hits produce one pulse.
//  In DRAIN, lanes continue to retire normally; no spawns occur.
// CONFIGURATION
//  ARROW_INVERT_EN defined: inversed_out[i] = LFSR[2] at spawn, held while ACTIVE.
//  ARROW_INVERT_EN undefined: inversed_out is tied to 0 and LFSR[2] is unused.
// STRUCTURE
//  arrow_pkg contains:
//   dir_t enum: DIR_DOWN=2'b00 (from top), DIR_UP=2'b01 (from bottom),
//    DIR_RIGHT=2'b10 (from left), DIR_LEFT=2'b11 (from right)
//   lane_state_t enum: FREE, ACTIVE, RETIRE
//   game_state_t enum: IDLE, RUN, DRAIN
//   LFSR_SEED=16'hACE1; MAX_LEVEL=6
//  Sub-module lfsr16 (clk, rst, state_out[15:0]): free-running LFSR, reset to LFSR_SEED.
//  Lane logic lives in a generate loop in arrow_spawner.
// TESTING
//  Setup: SPAWN_PERIOD=3, LIFE_FRAMES=10, NUM_SLOTS=2. Frame tick is one cycle every 16 clocks.
//  1. Basic spawn: raise game_active_in.
//     -> valid_out=2'b01 on the edge of the 3rd frame tick. direction_out[1:0] = LFSR[1:0] at that edge.
//     -> speed_out[2:0]=1.
//  2. Full lanes: hold hit_in=0 for 9 ticks.
//     -> lanes 0 and 1 go ACTIVE at ticks 3 and 6; the tick-9 attempt is dropped.
//     -> lane 0 retires at tick 12 (lifetime); hit_count_out stays 0.
//  3. Sticky hit: raise hit_in[0] and hold it high.
//     -> valid_out[0] is low for exactly 1 cycle; hit_pulse_out is a single pulse; hit_count_out=1.
//     -> on re-spawn, no further retire until hit_in[0] falls and rises again.
//  4. Simultaneous hits: hit_in=2'b11 rising on the same cycle.
//     -> hit_count_out +=2; one hit_pulse_out.
//     -> with hit_count_out=254, it saturates at 255.
//  5. Drain and reset: drop game_active_in.
//     -> no new spawns; busy_out falls once both lanes retire; FSM returns to IDLE.
//     -> assert rst mid-RUN: valid_out=0 asynchronously, before the next clk edge.
//  6. Level ramp: LEVEL_SPAWNS=2.
//     -> speed_out at spawns 1..16 = 1,1,2,2,3,3,...,7, then stays at 7.

Source files
------------

// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow spawner and its LFSR.
package arrow_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,  // enters from top
        DIR_UP    = 2'b01,  // enters from bottom
        DIR_RIGHT = 2'b10,  // enters from left
        DIR_LEFT  = 2'b11   // enters from right
    } dir_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        ACTIVE = 2'b01,
        RETIRE = 2'b10
    } lane_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          MAX_LEVEL = 6;

    // Fibonacci step, taps 16,14,13,11; a non-zero state never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/arrow_spawner_lfsr16.sv
// Free-running 16-bit LFSR used to pick arrow direction (and inversion).
module lfsr16
    import arrow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_out <= LFSR_SEED;
        end else begin
            state_out <= lfsr_next(state_out);
        end
    end

endmodule

// File: rtl/arrow_spawner.sv
// Arrow lane scheduler: periodic spawns, hit/lifetime retirement, hit counting, speed ramp.
// Optional ARROW_INVERT_EN: latch LFSR[2] into each lane's inversed flag at spawn.
module arrow_spawner
    import arrow_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_PERIOD = 60,
    parameter int LIFE_FRAMES  = 200,
    parameter int LEVEL_SPAWNS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_active_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic [NUM_SLOTS-1:0]   hit_in,
    output logic [NUM_SLOTS-1:0]   valid_out,
    output logic [2*NUM_SLOTS-1:0] direction_out,
    output logic [3*NUM_SLOTS-1:0] speed_out,
    output logic [NUM_SLOTS-1:0]   inversed_out,
    output logic                   hit_pulse_out,
    output logic [7:0]             hit_count_out,
    output logic                   busy_out
);

    localparam int SCNT_W = $clog2(SPAWN_PERIOD);
    localparam int LIFE_W = $clog2(LIFE_FRAMES);
    localparam int LVLC_W = $clog2(LEVEL_SPAWNS + 1);

    logic [15:0]          lfsr;
    game_state_t          g_state, g_next;
    logic                 frame_tick;
    logic                 spawn_wrap;
    logic                 spawn_found;
    logic [SCNT_W-1:0]    spawn_cnt;
    logic [LVLC_W-1:0]    lvl_cnt;
    logic [2:0]           level;
    logic [NUM_SLOTS-1:0] lane_free, spawn_sel, hit_q, hit_rise, hit_ret;
    logic [3:0]           n_hits;
    logic [8:0]           hc_sum;
    logic                 hit_any_q;
    logic                 lfsr_unused;

    lfsr16 u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .state_out (lfsr)
    );

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign spawn_wrap = (g_state == RUN) && frame_tick
                        && (spawn_cnt == SCNT_W'(SPAWN_PERIOD - 1));
    assign hit_rise   = hit_in & ~hit_q;
    assign busy_out   = ~&lane_free;

    // Global game FSM
    always_comb begin
        g_next = g_state;
        case (g_state)
            IDLE:    if (game_active_in) g_next = RUN;
            RUN:     if (!game_active_in) g_next = DRAIN;
            DRAIN:   if (game_active_in) g_next = RUN;
                     else if (&lane_free) g_next = IDLE;
            default: g_next = IDLE;
        endcase
    end

    // Lowest-index FREE lane wins a spawn; a RETIRE lane is not eligible yet.
    always_comb begin
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_wrap && lane_free[i] && !spawn_found) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    always_comb begin
        n_hits = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n_hits = n_hits + {3'b000, hit_ret[i]};
        end
        hc_sum = {1'b0, hit_count_out} + {5'b00000, n_hits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_state       <= IDLE;
            spawn_cnt     <= '0;
            lvl_cnt       <= '0;
            level         <= '0;
            hit_q         <= '0;
            hit_any_q     <= 1'b0;
            hit_pulse_out <= 1'b0;
            hit_count_out <= '0;
        end else begin
            g_state       <= g_next;
            hit_q         <= hit_in;
            hit_any_q     <= |hit_ret;
            hit_pulse_out <= hit_any_q;
            hit_count_out <= hc_sum[8] ? 8'hFF : hc_sum[7:0];
            if (g_state == IDLE && g_next == RUN) begin
                spawn_cnt <= '0;
                lvl_cnt   <= '0;
                level     <= '0;
            end else begin
                if (g_state == RUN && frame_tick) begin
                    spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + SCNT_W'(1);
                end
                if (spawn_found) begin
                    if (lvl_cnt == LVLC_W'(LEVEL_SPAWNS - 1)) begin
                        lvl_cnt <= '0;
                        if (level < 3'(MAX_LEVEL)) level <= level + 3'd1;
                    end else begin
                        lvl_cnt <= lvl_cnt + LVLC_W'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
        lane_state_t       st, st_next;
        logic [LIFE_W-1:0] life_cnt;
        dir_t              dir;
        logic [2:0]        spd;
        logic              life_end;

        // Life counter reaches LIFE_FRAMES-1 on the tick that retires the lane.
        assign life_end      = frame_tick && (life_cnt == LIFE_W'(LIFE_FRAMES - 2));
        assign hit_ret[i]    = (st == ACTIVE) && hit_rise[i];
        assign lane_free[i]  = (st == FREE);
        assign valid_out[i]  = (st == ACTIVE);
        assign direction_out[2*i +: 2] = dir;
        assign speed_out[3*i +: 3]     = spd;

        always_comb begin
            st_next = st;
            case (st)
                FREE:    if (spawn_sel[i]) st_next = ACTIVE;
                ACTIVE:  if (hit_rise[i] || life_end) st_next = RETIRE;
                RETIRE:  st_next = FREE;
                default: st_next = FREE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st       <= FREE;
                life_cnt <= '0;
                dir      <= DIR_DOWN;
                spd      <= '0;
            end else begin
                st <= st_next;
                if (spawn_sel[i]) begin
                    life_cnt <= '0;
                    dir      <= dir_t'(lfsr[1:0]);
                    spd      <= 3'd1 + level;
                end else if (st == ACTIVE && frame_tick) begin
                    life_cnt <= life_cnt + LIFE_W'(1);
                end
            end
        end

`ifdef ARROW_INVERT_EN
        logic inv;
        assign inversed_out[i] = inv;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                inv <= 1'b0;
            end else if (spawn_sel[i]) begin
                inv <= lfsr[2];
            end
        end
`else
        assign inversed_out[i] = 1'b0;
`endif
    end

`ifdef ARROW_INVERT_EN
    assign lfsr_unused = ^lfsr[15:3];
`else
    assign lfsr_unused = ^lfsr[15:2];
`endif

endmodule

// File: tb/tb_arrow_spawner.sv
// Bench for arrow_spawner: frame-level behavioural model plus directed scenarios.
module tb_arrow_spawner;

    localparam int NS = 2;
    localparam int SP = 3;
    localparam int LF = 10;
    localparam int LS = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            game_active_in = 1'b0;
    logic [10:0]     hcount_in = '0;
    logic [9:0]      vcount_in = '0;
    logic [NS-1:0]   hit_in = '0;
    logic [NS-1:0]   valid_out;
    logic [2*NS-1:0] direction_out;
    logic [3*NS-1:0] speed_out;
    logic [NS-1:0]   inversed_out;
    logic            hit_pulse_out;
    logic [7:0]      hit_count_out;
    logic            busy_out;

    int errors = 0;
    int checks = 0;
    int nticks = 0;

    always #5 clk = ~clk;

    arrow_spawner #(
        .NUM_SLOTS    (NS),
        .SPAWN_PERIOD (SP),
        .LIFE_FRAMES  (LF),
        .LEVEL_SPAWNS (LS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_active_in (game_active_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .hit_in         (hit_in),
        .valid_out      (valid_out),
        .direction_out  (direction_out),
        .speed_out      (speed_out),
        .inversed_out   (inversed_out),
        .hit_pulse_out  (hit_pulse_out),
        .hit_count_out  (hit_count_out),
        .busy_out       (busy_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // game: 0 idle, 1 run, 2 drain; lane: 0 free, 1 active, 2 retiring
    int          m_g, m_scnt, m_nsp, m_hits;
    int          m_st [NS];
    int          m_age[NS];
    int          m_spd[NS];
    logic [1:0]  m_dir[NS];
    logic        m_inv[NS];
    logic [15:0] m_lfsr;
    logic [NS-1:0] m_hprev;
    bit          m_pd, m_pulse;

    always @(posedge clk or negedge rst) begin
        bit            tick, all_free;
        logic [NS-1:0] rise;
        int            nh, lane, lvl;
        int            old_st[NS];
        if (!rst) begin
            m_g = 0; m_scnt = 0; m_nsp = 0; m_hits = 0;
            m_lfsr = 16'hACE1; m_hprev = '0; m_pd = 0; m_pulse = 0;
            for (int i = 0; i < NS; i++) begin
                m_st[i] = 0; m_age[i] = 0; m_spd[i] = 0; m_dir[i] = 2'b00; m_inv[i] = 1'b0;
            end
        end else begin
            tick = (hcount_in == 0) && (vcount_in == 0);
            rise = hit_in & ~m_hprev;
            nh = 0;
            all_free = 1;
            for (int i = 0; i < NS; i++) begin
                old_st[i] = m_st[i];
                if (m_st[i] != 0) all_free = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (old_st[i] == 2) begin
                    m_st[i] = 0;
                end else if (old_st[i] == 1) begin
                    if (rise[i]) begin
                        m_st[i] = 2;
                        nh++;
                    end else if (tick) begin
                        m_age[i]++;
                        if (m_age[i] == LF - 1) m_st[i] = 2;
                    end
                end
            end
            if (m_g == 1 && tick) begin
                if (m_scnt == SP - 1) begin
                    m_scnt = 0;
                    lane = -1;
                    for (int i = 0; i < NS; i++) if (lane < 0 && old_st[i] == 0) lane = i;
                    if (lane >= 0) begin
                        lvl = m_nsp / LS;
                        if (lvl > 6) lvl = 6;
                        m_st[lane]  = 1;
                        m_age[lane] = 0;
                        m_dir[lane] = m_lfsr[1:0];
                        m_spd[lane] = 1 + lvl;
                        m_inv[lane] = m_lfsr[2];
                        m_nsp++;
                    end
                end else begin
                    m_scnt++;
                end
            end
            case (m_g)
                0: if (game_active_in) begin m_g = 1; m_scnt = 0; m_nsp = 0; end
                1: if (!game_active_in) m_g = 2;
                default: if (game_active_in) m_g = 1; else if (all_free) m_g = 0;
            endcase
            m_hits  = (m_hits + nh > 255) ? 255 : m_hits + nh;
            m_pulse = m_pd;
            m_pd    = (nh > 0);
            m_hprev = hit_in;
            m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NS-1:0]   ev, einv;
        logic [2*NS-1:0] ed;
        logic [3*NS-1:0] es;
        logic            eb;
        if (rst) begin
            eb = 1'b0;
            for (int i = 0; i < NS; i++) begin
                ev[i]        = (m_st[i] == 1);
                ed[2*i +: 2] = m_dir[i];
                es[3*i +: 3] = 3'(m_spd[i]);
`ifdef ARROW_INVERT_EN
                einv[i]      = m_inv[i];
`else
                einv[i]      = 1'b0;
`endif
                if (m_st[i] != 0) eb = 1'b1;
            end
            chk("model_valid", 32'(valid_out), 32'(ev));
            chk("model_dir", 32'(direction_out), 32'(ed));
            chk("model_speed", 32'(speed_out), 32'(es));
            chk("model_inv", 32'(inversed_out), 32'(einv));
            chk("model_pulse", 32'(hit_pulse_out), 32'(m_pulse));
            chk("model_hits", 32'(hit_count_out), 32'(m_hits));
            chk("model_busy", 32'(busy_out), 32'(eb));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        if (hcount_in == 0 && vcount_in == 0) nticks++;
        @(posedge clk);
        #1;
        hcount_in = (hcount_in == 11'd15) ? 11'd0 : hcount_in + 11'd1;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = nticks + n;
        while (nticks < target) step();
    endtask

    task automatic wait_valid(input logic [NS-1:0] mask, input int budget, input string name);
        int k;
        k = 0;
        while ((valid_out & mask) != mask && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(valid_out & mask), 32'(mask));
    endtask

    task automatic double_hit(input logic [NS-1:0] h);
        hit_in = h;
        step();
        hit_in = '0;
        step();
    endtask

    logic [2:0] exp_spd [16] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            rounds, k, lane;
        bit            spawned;
        logic [NS-1:0] prev_v;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_dir", 32'(direction_out), 0);
        chk("rst_speed", 32'(speed_out), 0);
        chk("rst_count", 32'(hit_count_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_pulse", 32'(hit_pulse_out), 0);
        step();
        step();
        rst = 1'b1;

        // 1. Basic spawn on the 3rd frame tick
        game_active_in = 1'b1;
        wait_ticks(2);
        chk("t1_no_spawn_yet", 32'(valid_out), 0);
        wait_ticks(1);
        chk("t1_valid", 32'(valid_out), 32'h1);
        chk("t1_speed", 32'(speed_out[2:0]), 1);

        // 2. Lanes fill, dropped attempt, lifetime retire
        wait_ticks(3);
        chk("t2_tick6", 32'(valid_out), 32'h3);
        wait_ticks(3);
        chk("t2_tick9_dropped", 32'(valid_out), 32'h3);
        wait_ticks(3);
        chk("t2_tick12_retire", 32'(valid_out), 32'h2);
        chk("t2_busy", 32'(busy_out), 1);
        step();
        chk("t2_free", 32'(valid_out), 32'h2);
        chk("t2_no_hits", 32'(hit_count_out), 0);
        wait_ticks(3);
        chk("t2_tick15", 32'(valid_out), 32'h1);

        // 3. Sticky hit on lane 0
        hit_in = 2'b01;
        step();
        chk("t3_retire", 32'(valid_out), 0);
        chk("t3_count", 32'(hit_count_out), 1);
        chk("t3_pulse_wait", 32'(hit_pulse_out), 0);
        step();
        chk("t3_pulse", 32'(hit_pulse_out), 1);
        step();
        chk("t3_pulse_end", 32'(hit_pulse_out), 0);
        wait_ticks(6);
        chk("t3_sticky_respawn", 32'(valid_out), 32'h3);
        chk("t3_sticky_count", 32'(hit_count_out), 1);
        hit_in = 2'b00;
        step();
        hit_in = 2'b01;
        step();
        chk("t3_rehit", 32'(valid_out), 32'h2);
        chk("t3_rehit_count", 32'(hit_count_out), 2);
        hit_in = 2'b00;
        step();

        // 4. Simultaneous hits, then saturation
        wait_valid(2'b11, 400, "t4_wait_both");
        hit_in = 2'b11;
        step();
        hit_in = 2'b00;
        chk("t4_both_retire", 32'(valid_out), 0);
        chk("t4_count", 32'(hit_count_out), 4);
        step();
        chk("t4_one_pulse", 32'(hit_pulse_out), 1);
        step();
        chk("t4_pulse_end", 32'(hit_pulse_out), 0);
        rounds = 0;
        while (m_hits < 254 && rounds < 200) begin
            wait_valid(2'b11, 400, "t4_fill_wait");
            double_hit((m_hits == 253) ? 2'b01 : 2'b11);
            rounds++;
        end
        chk("t4_at_254", 32'(hit_count_out), 254);
        wait_valid(2'b11, 400, "t4_wait_sat");
        double_hit(2'b11);
        chk("t4_sat_255", 32'(hit_count_out), 255);
        wait_valid(2'b11, 400, "t4_wait_sat2");
        double_hit(2'b11);
        chk("t4_stay_255", 32'(hit_count_out), 255);

        // 5. Drain: no spawns, busy falls, back to IDLE
        wait_valid(2'b11, 400, "t5_wait_both");
        game_active_in = 1'b0;
        spawned = 0;
        k = 0;
        prev_v = valid_out;
        while (busy_out && k < 300) begin
            step();
            if ((valid_out & ~prev_v) != 0) spawned = 1;
            prev_v = valid_out;
            k++;
        end
        chk("t5_busy_fell", 32'(busy_out), 0);
        chk("t5_no_spawn", 32'(spawned), 0);
        chk("t5_valid", 32'(valid_out), 0);
        step();
        step();
        while (hcount_in == 0) step();
        game_active_in = 1'b1;
        wait_ticks(2);
        chk("t5_restart_wait", 32'(valid_out), 0);
        wait_ticks(1);
        chk("t5_restart_spawn", 32'(valid_out), 32'h1);
        chk("t5_level_cleared", 32'(speed_out[2:0]), 1);

        // Asynchronous reset mid-run
        #3 rst = 1'b0;
        #1;
        chk("t5_async_valid", 32'(valid_out), 0);
        chk("t5_async_busy", 32'(busy_out), 0);
        chk("t5_async_count", 32'(hit_count_out), 0);
        step();
        rst = 1'b1;

        // 6. Level ramp with LEVEL_SPAWNS=2
        for (int s = 0; s < 16; s++) begin
            k = 0;
            while (valid_out == 0 && k < 200) begin
                step();
                k++;
            end
            chk("t6_spawned", 32'(valid_out != 0), 1);
            lane = valid_out[0] ? 0 : 1;
            chk($sformatf("t6_speed%0d", s + 1), 32'(speed_out[3*lane +: 3]), 32'(exp_spd[s]));
            hit_in[lane] = 1'b1;
            step();
            hit_in = '0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
